// File: rtl/text_cell_fetch.sv
// Character-cell fetch: maps pixel counters to an 80x60 grid of 8x8 cells, reads
// the cell word from text RAM and resolves fg/bg through a 16-entry palette.
//   state   | meaning
//   ST_IDLE | host writes accepted, display reads only
//   ST_FILL | clear-screen fill writes one cell per clock, host stalled
module text_cell_fetch #(
  parameter int HSZ  = 10,
  parameter int VSZ  = 9,
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [HSZ-1:0] hcount_i,
  input  logic [VSZ-1:0] vcount_i,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  input  logic           wr_valid_i,
  output logic           wr_ready_o,
  input  logic [12:0]    wr_addr_i,
  input  logic [15:0]    wr_data_i,
  output logic           busy_o,
  output logic [7:0]     char_o,
  output logic [2:0]     row_o,
  output logic [2:0]     column_o,
  output logic [11:0]    fg_color_o,
  output logic [11:0]    bg_color_o,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [12:0] LAST_CELL = 13'(CELLS - 1);
  localparam logic [12:0] CLR_ADDR  = 13'h1FFF;

  typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [12:0] ptr_q, ptr_d;
  logic [15:0] fill_q, fill_d;
  logic        rdy_q;
  logic        wr_accept;

  // rdy_q keeps wr_ready_o low until the first edge after reset release
  assign wr_ready_o = rdy_q && (state_q == ST_IDLE);
  assign busy_o     = (state_q == ST_FILL);
  assign wr_accept  = wr_valid_i && wr_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_accept && (wr_addr_i == CLR_ADDR)) begin
          state_d = ST_FILL;
          ptr_d   = '0;
          fill_d  = wr_data_i;
        end
      end
      ST_FILL: begin
        if (ptr_q == LAST_CELL) state_d = ST_IDLE;
        else                    ptr_d   = ptr_q + 13'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [15:0] mem [CELLS];
  logic        ram_we;
  logic [12:0] ram_waddr;
  logic [15:0] ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr_i;
    ram_wdata = wr_data_i;
    if (state_q == ST_FILL) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = fill_q;
    end else if (wr_accept && (wr_addr_i < 13'(CELLS))) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  logic [11:0] pal_q [16];
  logic        pal_we;

  assign pal_we = wr_accept && (wr_addr_i[12:4] == 9'h130);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
    end else if (pal_we) begin
      pal_q[wr_addr_i[3:0]] <= wr_data_i[11:0];
    end
  end

  logic [12:0] cell_addr;

  always_comb begin
    if ((hcount_i >= HSZ'(COLS * 8)) || (vcount_i >= VSZ'(ROWS * 8)))
      cell_addr = '0;
    else
      cell_addr = 13'(vcount_i[VSZ-1:3]) * 13'(COLS) + 13'(hcount_i[HSZ-1:3]);
  end

  logic [12:0] addr_s0_q;
  logic [2:0]  ctl_s0_q, ctl_s1_q;
  logic [2:0]  row_s0_q, row_s1_q, col_s0_q, col_s1_q;
  logic [15:0] word_s1_q;

  // ctl = {de, hsync, vsync}; the RAM read sees the old word on a same-cycle write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_s0_q  <= '0;
      ctl_s0_q   <= '0;
      row_s0_q   <= '0;
      col_s0_q   <= '0;
      word_s1_q  <= '0;
      ctl_s1_q   <= '0;
      row_s1_q   <= '0;
      col_s1_q   <= '0;
      char_o     <= '0;
      fg_color_o <= '0;
      bg_color_o <= '0;
      row_o      <= '0;
      column_o   <= '0;
      de_o       <= 1'b0;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
    end else begin
      addr_s0_q  <= cell_addr;
      ctl_s0_q   <= {de_i, hsync_i, vsync_i};
      row_s0_q   <= vcount_i[2:0];
      col_s0_q   <= hcount_i[2:0];
      word_s1_q  <= mem[addr_s0_q];
      ctl_s1_q   <= ctl_s0_q;
      row_s1_q   <= row_s0_q;
      col_s1_q   <= col_s0_q;
      char_o     <= ctl_s1_q[2] ? word_s1_q[7:0] : 8'd0;
      fg_color_o <= ctl_s1_q[2] ? pal_q[word_s1_q[11:8]] : 12'd0;
      bg_color_o <= ctl_s1_q[2] ? pal_q[word_s1_q[15:12]] : 12'd0;
      row_o      <= row_s1_q;
      column_o   <= col_s1_q;
      de_o       <= ctl_s1_q[2];
      hsync_o    <= ctl_s1_q[1];
      vsync_o    <= ctl_s1_q[0];
    end
  end

endmodule

// File: tb/tb_text_cell_fetch.sv
// Randomized bench for text_cell_fetch against an array-based model of the
// text RAM and palette, with directed fill, collision and reset scenarios.
module tb_text_cell_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  hcount_i;
  logic [8:0]  vcount_i;
  logic        de_i, hsync_i, vsync_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [12:0] wr_addr_i;
  logic [15:0] wr_data_i;
  logic        busy_o;
  logic [7:0]  char_o;
  logic [2:0]  row_o, column_o;
  logic [11:0] fg_color_o, bg_color_o;
  logic        de_o, hsync_o, vsync_o;

  text_cell_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .busy_o(busy_o), .char_o(char_o), .row_o(row_o),
    .column_o(column_o), .fg_color_o(fg_color_o), .bg_color_o(bg_color_o),
    .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem_m [4800];
  logic [11:0] pal_m [16];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (h >= 640 || v >= 480) return 0;
    return (v / 8) * 80 + h / 8;
  endfunction

  function automatic void pal_reset_m();
    for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
  endfunction

  task automatic host_write(input int addr, input int data, output int waits);
    waits = 0;
    wr_valid_i = 1'b1;
    wr_addr_i  = 13'(addr);
    wr_data_i  = 16'(data);
    while (!wr_ready_o && waits < 10000) begin
      tick();
      waits++;
    end
    if (!wr_ready_o) begin
      chk("wr_timeout", 0, 1);
    end else begin
      tick();
      if (addr < 4800) mem_m[addr] = 16'(data);
      if ((addr >> 4) == 'h130) pal_m[addr & 15] = 12'(data);
    end
    wr_valid_i = 1'b0;
  endtask

  task automatic set_pix(input int h, input int v, input bit de, input bit hs, input bit vs);
    hcount_i = 10'(h);
    vcount_i = 9'(v);
    de_i = de;
    hsync_i = hs;
    vsync_i = vs;
  endtask

  task automatic probe(input int h, input int v, input bit de, input bit hs, input bit vs);
    logic [15:0] w;
    set_pix(h, v, de, hs, vs);
    repeat (3) tick();
    w = mem_m[exp_addr(h, v)];
    chk("char", int'(char_o), de ? int'(w[7:0]) : 0);
    chk("fg", int'(fg_color_o), de ? int'(pal_m[w[11:8]]) : 0);
    chk("bg", int'(bg_color_o), de ? int'(pal_m[w[15:12]]) : 0);
    chk("row", int'(row_o), v % 8);
    chk("col", int'(column_o), h % 8);
    chk("de", int'(de_o), int'(de));
    chk("hsync", int'(hsync_o), int'(hs));
    chk("vsync", int'(vsync_o), int'(vs));
  endtask

  task automatic fill_model(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) mem_m[i] = w;
  endtask

  initial begin
    int waits, n, rdy_seen, a, d;
    logic [15:0] old_w;
    logic [11:0] old_fg;
    bit [2:0] q[$];
    bit [2:0] cur, exp_c;

    rst_i = 1'b1;
    wr_valid_i = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    set_pix(0, 0, 1'b1, 1'b0, 1'b0);
    pal_reset_m();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", int'(wr_ready_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_char", int'(char_o), 0);
    chk("rst_fg", int'(fg_color_o), 0);
    chk("rst_bg", int'(bg_color_o), 0);
    chk("rst_de", int'(de_o), 0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", int'(wr_ready_o), 1);

    // full clear-screen fill
    host_write('h1FFF, 'hF041, waits);
    n = 0;
    rdy_seen = 0;
    while (busy_o && n < 6000) begin
      if (wr_ready_o) rdy_seen++;
      n++;
      tick();
    end
    chk("fill_len", n, 4800);
    chk("fill_ready_low", rdy_seen, 0);
    fill_model(16'hF041, 4800);
    probe(639, 479, 1'b1, 1'b0, 1'b0);
    probe(0, 0, 1'b1, 1'b0, 1'b0);

    host_write(81, 'h2A5B, waits);
    host_write('h130A, 'hF0F0, waits);
    host_write('h1302, 'h0F00, waits);
    probe(8, 8, 1'b1, 1'b0, 1'b0);
    probe(13, 14, 1'b1, 1'b1, 1'b0);
    probe(700, 100, 1'b0, 1'b1, 1'b1);

    // single-cycle sync/enable pulses streamed through the pipe
    set_pix(8, 8, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    q.delete();
    for (int i = 0; i < 40; i++) begin
      cur = 3'($urandom_range(0, 7));
      set_pix(8, 8, cur[2], cur[1], cur[0]);
      q.push_back(cur);
      tick();
      if (q.size() == 3) begin
        exp_c = q.pop_front();
        chk("p_de", int'(de_o), int'(exp_c[2]));
        chk("p_hs", int'(hsync_o), int'(exp_c[1]));
        chk("p_vs", int'(vsync_o), int'(exp_c[0]));
        chk("p_char", int'(char_o), exp_c[2] ? int'(mem_m[81][7:0]) : 0);
        chk("p_fg", int'(fg_color_o), exp_c[2] ? int'(pal_m[mem_m[81][11:8]]) : 0);
      end
    end

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom_range(0, 4799);
          host_write(a, int'($urandom_range(0, 65535)), waits);
          probe((a % 80) * 8 + $urandom_range(0, 7), (a / 80) * 8 + $urandom_range(0, 7),
                1'b1, 1'($urandom), 1'($urandom));
        end
        1: host_write('h1300 + $urandom_range(0, 15), int'($urandom_range(0, 65535)), waits);
        2: host_write($urandom_range(4800, 'h12FF), int'($urandom_range(0, 65535)), waits);
        default: ;
      endcase
      probe($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // same-cycle cell write and palette write give the old value first
    set_pix(16, 8, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    old_w = mem_m[82];
    d = int'(old_w) ^ 'h00A5;
    host_write(82, d, waits);
    chk("coll_ram_cur", int'(char_o), int'(old_w[7:0]));
    tick();
    chk("coll_ram_old", int'(char_o), int'(old_w[7:0]));
    tick();
    chk("coll_ram_new", int'(char_o), d & 'hFF);
    old_fg = pal_m[mem_m[82][11:8]];
    host_write('h1300 + int'(mem_m[82][11:8]), int'(old_fg ^ 12'h5A5), waits);
    chk("coll_pal_old", int'(fg_color_o), int'(old_fg));
    tick();
    chk("coll_pal_new", int'(fg_color_o), int'(old_fg ^ 12'h5A5));

    // reset 100 clocks into a fill
    host_write('h1FFF, 'h3C77, waits);
    repeat (100) tick();
    rst_i = 1'b1;
    #1;
    chk("rst_fill_busy", int'(busy_o), 0);
    chk("rst_fill_ready", int'(wr_ready_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    chk("rst_fill_ready_rel", int'(wr_ready_o), 1);
    fill_model(16'h3C77, 100);
    pal_reset_m();
    probe(0, 0, 1'b1, 1'b0, 1'b0);
    probe(152, 8, 1'b1, 1'b0, 1'b0);
    probe(160, 8, 1'b1, 1'b0, 1'b0);

    // host write held across a whole fill
    host_write('h1FFF, 'h5A5A, waits);
    host_write(5, 'h1234, waits);
    chk("hold_waits", waits, 4800);
    chk("hold_busy", int'(busy_o), 0);
    fill_model(16'h5A5A, 4800);
    mem_m[5] = 16'h1234;
    probe(40, 0, 1'b1, 1'b0, 1'b0);
    probe(32, 0, 1'b1, 1'b0, 1'b0);
    probe(48, 0, 1'b1, 1'b0, 1'b0);
    probe(632, 472, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
